// File: rtl/my_oc_parity_pkg.sv
// ---------------------------------------------------------------------------
// my_oc_pkg
// Shared constants and types for the registered open-collector parity gate.
//   OC_SINK     : level driven onto w while sinking
//   OC_RELEASE  : level driven onto w while released (high impedance)
//   oc_state_t  : state of the sink register (OC_OFF = released, OC_ON = sinking)
//   oc_parity3  : reference odd-parity helper for three bits
// ---------------------------------------------------------------------------
package my_oc_pkg;

  localparam logic OC_SINK    = 1'b0;
  localparam logic OC_RELEASE = 1'bz;

  typedef enum logic {
    OC_OFF = 1'b0,
    OC_ON  = 1'b1
  } oc_state_t;

  function automatic logic oc_parity3(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/my_oc_parity_if.sv
// ---------------------------------------------------------------------------
// my_oc_parity_if
// Data bundle between a driver of the parity gate and the gate itself.
//   a, b, c : data inputs sampled every rising edge of clk
//   y0      : registered push-pull parity returned by the gate
// Modports:
//   master  : drives a/b/c, observes y0
//   slave   : the gate; observes a/b/c, drives y0
// The open-collector output w is kept out of this bundle on purpose: it has
// to land on a net shared with other instances, not on a per-instance bus.
// ---------------------------------------------------------------------------
interface my_oc_parity_if;

  logic a;
  logic b;
  logic c;
  logic y0;

  modport master (
    output a,
    output b,
    output c,
    input  y0
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    output y0
  );

endinterface

// File: rtl/my_oc_parity_parity3.sv
// ---------------------------------------------------------------------------
// parity3
// Pure combinational 3-input parity, p = a ^ b ^ c (1 when odd).
// Ports:
//   a, b, c : data inputs
//   p       : parity output
// ---------------------------------------------------------------------------
module parity3
  import my_oc_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic p
);

  assign p = oc_parity3(a, b, c);

endmodule

// File: rtl/my_oc_parity.sv
// ---------------------------------------------------------------------------
// my_oc_parity
// Registered 3-input parity gate with an open-collector output.
// w sinks low one clock after even parity on a/b/c and is released one clock
// after odd parity, so several instances can share one pulled-up net as a
// wired-AND. y0 is the registered push-pull parity.
//
// Parameters:
//   RESET_SINK : sink state loaded by reset (0 = released, 1 = sinking)
// Ports:
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous, active-high reset (wins over the data sample)
//   bus  : my_oc_parity_if.slave carrying a/b/c in and y0 out
//   w    : open-collector output (0 when sinking, Z when released)
//
// Build option:
//   MY_OC_PUSHPULL_EN : when defined, the released state of w is driven 1
//                       instead of Z; y0 is unaffected.
// ---------------------------------------------------------------------------
module my_oc_parity
  import my_oc_pkg::*;
#(
  parameter logic RESET_SINK = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  my_oc_parity_if.slave      bus,
  output wire                w
);

  logic      p;
  logic      y0_d;
  logic      y0_q;
  oc_state_t sink_d;
  oc_state_t sink_q;

  parity3 u_parity3 (
    .a (bus.a),
    .b (bus.b),
    .c (bus.c),
    .p (p)
  );

  always_comb begin
    y0_d   = p;
    sink_d = p ? OC_OFF : OC_ON;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sink_q <= RESET_SINK ? OC_ON : OC_OFF;
      y0_q   <= ~RESET_SINK;
    end else begin
      sink_q <= sink_d;
      y0_q   <= y0_d;
    end
  end

  assign bus.y0 = y0_q;

  // The only driver of w.
`ifdef MY_OC_PUSHPULL_EN
  assign w = (sink_q == OC_ON) ? OC_SINK : 1'b1;
`else
  assign w = (sink_q == OC_ON) ? OC_SINK : OC_RELEASE;
`endif

endmodule

// File: tb/tb_my_oc_parity.sv
// ---------------------------------------------------------------------------
// tb_my_oc_parity
// Bench for my_oc_parity. All w nets carry a pull-up, so a released output
// reads 1 in both the open-collector and the push-pull build.
// ---------------------------------------------------------------------------
module tb_my_oc_parity;

  localparam logic RS = 1'b0;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  my_oc_parity_if if_m ();
  my_oc_parity_if if_wa ();
  my_oc_parity_if if_wb ();

  wire w_main;
  wire w_wired;

  pullup (w_main);
  pullup (w_wired);

  my_oc_parity #(.RESET_SINK(RS)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if_m.slave),
    .w   (w_main)
  );

  my_oc_parity #(.RESET_SINK(RS)) u_wa (
    .clk (clk),
    .rst (rst),
    .bus (if_wa.slave),
    .w   (w_wired)
  );

  my_oc_parity #(.RESET_SINK(RS)) u_wb (
    .clk (clk),
    .rst (rst),
    .bus (if_wb.slave),
    .w   (w_wired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: released (reads 1 on a pulled-up net) iff odd count of ones.
  function automatic logic is_odd(input logic [2:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic drive(input logic [2:0] m, input logic [2:0] wa, input logic [2:0] wb,
                       input logic r);
    {if_m.a, if_m.b, if_m.c}    = m;
    {if_wa.a, if_wa.b, if_wa.c} = wa;
    {if_wb.a, if_wb.b, if_wb.c} = wb;
    rst = r;
  endtask

  // Apply inputs at the falling edge, then check everything just after the
  // following rising edge against the reference model.
  task automatic step(input logic [2:0] m, input logic [2:0] wa, input logic [2:0] wb,
                      input logic r, input string tag);
    logic exp_y0;
    logic exp_w;
    logic exp_net;
    @(negedge clk);
    drive(m, wa, wb, r);
    @(posedge clk);
    if (r) begin
      exp_y0  = ~RS;
      exp_w   = ~RS;
      exp_net = ~RS;
    end else begin
      exp_y0  = is_odd(m);
      exp_w   = is_odd(m);
      exp_net = is_odd(wa) && is_odd(wb);
    end
    #1;
    chk({tag, "_y0"}, if_m.y0, exp_y0);
    chk({tag, "_w"}, w_main, exp_w);
    chk({tag, "_net"}, w_wired, exp_net);
  endtask

  initial begin
    logic [2:0] even_v [4];
    logic [2:0] odd_v [4];
    n_checks = 0;
    n_fail   = 0;
    even_v = '{3'b000, 3'b011, 3'b101, 3'b110};
    odd_v  = '{3'b001, 3'b010, 3'b100, 3'b111};
    drive(3'b000, 3'b000, 3'b000, 1'b1);

    // Reset for two cycles with abc = 000.
    step(3'b000, 3'b000, 3'b000, 1'b1, "rst0");
    step(3'b000, 3'b000, 3'b000, 1'b1, "rst1");
    step(3'b000, 3'b000, 3'b000, 1'b0, "rst_rel");

    foreach (even_v[i]) step(even_v[i], even_v[i], odd_v[i], 1'b0, "even");
    foreach (odd_v[i])  step(odd_v[i], odd_v[i], odd_v[(i + 1) % 4], 1'b0, "odd");

    // Wired-AND: one released, one sinking -> net low; both released -> high.
    step(3'b000, 3'b001, 3'b011, 1'b0, "wand_mix");
    step(3'b000, 3'b001, 3'b111, 1'b0, "wand_odd");

    // Latency: change mid-cycle, w must hold until the next rising edge.
    step(3'b000, 3'b000, 3'b000, 1'b0, "lat_pre");
    @(negedge clk);
    {if_m.a, if_m.b, if_m.c} = 3'b001;
    #2;
    chk("lat_hold_w", w_main, 1'b0);
    chk("lat_hold_y0", if_m.y0, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_edge_w", w_main, 1'b1);
    chk("lat_edge_y0", if_m.y0, 1'b1);

    // Glitch: a pulse that does not span an edge has no effect.
    step(3'b000, 3'b000, 3'b000, 1'b0, "glt_pre");
    @(negedge clk);
    {if_m.a, if_m.b, if_m.c} = 3'b001;
    #2;
    {if_m.a, if_m.b, if_m.c} = 3'b000;
    @(posedge clk);
    #1;
    chk("glt_w", w_main, 1'b0);
    chk("glt_y0", if_m.y0, 1'b0);

    // Reset mid-stream overrides the pending sample.
    step(3'b000, 3'b000, 3'b000, 1'b0, "mid_pre");
    step(3'b000, 3'b000, 3'b000, 1'b1, "mid_rst");
    step(3'b000, 3'b000, 3'b000, 1'b0, "mid_post");

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 60; k++) begin
      step(3'($urandom), 3'($urandom), 3'($urandom), ($urandom_range(0, 9) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
